// File: rtl/fetch_queue_if.sv
// Fetch-stage bus: the cache request/response pair, decode stall and redirects, and the FIFO head.
// The master modport belongs to fetch_queue; the slave side is the cache/decode environment.
interface fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic [XLEN-1:0] req_addr;
  logic            cache_ack;
  logic [XLEN-1:0] cache_inst;
  logic            stall;
  logic            jal;
  logic            branch;
  logic [XLEN-1:0] j_target;
  logic [XLEN-1:0] b_target;
  logic            out_valid;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_inst;

  modport master (
    output req_valid, req_addr, out_valid, out_pc, out_inst,
    input  cache_ack, cache_inst, stall, jal, branch, j_target, b_target
  );

  modport slave (
    input  req_valid, req_addr, out_valid, out_pc, out_inst,
    output cache_ack, cache_inst, stall, jal, branch, j_target, b_target
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage with a DEPTH-entry {pc, inst} prefetch FIFO between the instruction cache and decode.
// Keeps one cache request in flight, flushes on jal/branch and drops stale responses.
module fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [XLEN-1:0] NOP      = XLEN'(32'h0000_0013)
) (
  input  logic          clk,
  input  logic          rst,
  fetch_queue_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // state     | meaning
  // IDLE      | nothing outstanding; may issue this cycle
  // WAIT      | request for fetch_pc outstanding, FIFO space reserved
  // WAIT_DROP | stale request outstanding; its response is discarded
  typedef enum logic [1:0] {IDLE, WAIT, WAIT_DROP} state_t;

  state_t          state;
  logic [XLEN-1:0] fetch_pc;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];

  logic            redir;
  logic [XLEN-1:0] redir_tgt;
  logic            not_empty;
  logic            full;
  logic            pop;
  logic            issue;
  logic            push;
  logic [XLEN-1:0] push_pc;
  logic [PW-1:0]   push_idx;

  always_comb begin
    redir     = bus.jal | bus.branch;
    redir_tgt = bus.jal ? bus.j_target : bus.b_target;
    not_empty = (count != '0);
    full      = (count == CW'(DEPTH));
    pop       = not_empty && !bus.stall && !redir;
    issue     = 1'b0;
    push      = 1'b0;
    push_pc   = fetch_pc;
    bus.req_addr = fetch_pc;
    // No request while reset is held, even though the state reads IDLE.
    if (rst) begin
      case (state)
        IDLE: begin
          if (redir) begin
            issue        = 1'b1;
            bus.req_addr = redir_tgt;
            push_pc      = redir_tgt;
            push         = bus.cache_ack;
          end else if (!full || pop) begin
            issue = 1'b1;
            push  = bus.cache_ack;
          end
        end
        WAIT:    push = bus.cache_ack && !redir;
        default: ;
      endcase
    end
    bus.req_valid = issue;
    push_idx      = redir ? '0 : wr_ptr;
    bus.out_valid = not_empty;
    bus.out_pc    = not_empty ? pc_mem[rd_ptr] : RESET_PC - XLEN'(4);
    bus.out_inst  = not_empty ? inst_mem[rd_ptr] : NOP;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[push_idx]   <= push_pc;
      inst_mem[push_idx] <= bus.cache_inst;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      // A redirect empties the FIFO; only a same-cycle hit on the target survives.
      if (redir) begin
        rd_ptr <= '0;
        wr_ptr <= push ? PW'(1) : '0;
        count  <= push ? CW'(1) : '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        if (push && !pop)      count <= count + 1'b1;
        else if (pop && !push) count <= count - 1'b1;
      end

      case (state)
        IDLE: begin
          if (redir) begin
            fetch_pc <= bus.cache_ack ? redir_tgt + XLEN'(4) : redir_tgt;
            state    <= bus.cache_ack ? IDLE : WAIT;
          end else if (issue) begin
            if (bus.cache_ack) fetch_pc <= fetch_pc + XLEN'(4);
            else               state    <= WAIT;
          end
        end
        WAIT: begin
          if (redir) begin
            fetch_pc <= redir_tgt;
            state    <= bus.cache_ack ? IDLE : WAIT_DROP;
          end else if (bus.cache_ack) begin
            fetch_pc <= fetch_pc + XLEN'(4);
            state    <= IDLE;
          end
        end
        WAIT_DROP: begin
          if (redir)         fetch_pc <= redir_tgt;
          if (bus.cache_ack) state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed scenarios for fetch_queue; expected requests and FIFO pops are queued by the
// stimulus and consumed by an independent monitor on the falling edge.
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic        hit_mode  = 1'b0;
  logic        miss_ack  = 1'b0;
  logic [31:0] miss_inst = '0;

  logic [31:0] exp_req [$];
  logic [63:0] exp_out [$];

  fetch_queue_if #(.XLEN(32)) bus ();

  fetch_queue #(
    .XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .NOP(32'h0000_0013)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] hit_inst(input logic [31:0] a);
    return 32'hDEAD_0000 ^ a;
  endfunction

  // Cache model: always-hit returns a pc-derived word; otherwise the stimulus drives the ack.
  always_comb begin
    if (hit_mode) begin
      bus.cache_ack  = 1'b1;
      bus.cache_inst = hit_inst(bus.req_addr);
    end else begin
      bus.cache_ack  = miss_ack;
      bus.cache_inst = miss_inst;
    end
  end

  always @(negedge clk) begin
    logic [31:0] er;
    logic [63:0] eo;
    if (rst) begin
      if (bus.req_valid) begin
        checks++;
        if (exp_req.size() == 0) begin
          errors++;
          $display("FAIL req_addr: unexpected request to 0x%h at %0t", bus.req_addr, $time);
        end else begin
          er = exp_req.pop_front();
          if (bus.req_addr !== er) begin
            errors++;
            $display("FAIL req_addr: got 0x%h expected 0x%h at %0t", bus.req_addr, er, $time);
          end
        end
      end
      if (bus.out_valid && !bus.stall && !bus.jal && !bus.branch) begin
        checks++;
        if (exp_out.size() == 0) begin
          errors++;
          $display("FAIL pop: unexpected pop pc=0x%h inst=0x%h at %0t", bus.out_pc, bus.out_inst, $time);
        end else begin
          eo = exp_out.pop_front();
          if ({bus.out_pc, bus.out_inst} !== eo) begin
            errors++;
            $display("FAIL pop: got pc=0x%h inst=0x%h expected pc=0x%h inst=0x%h at %0t",
                     bus.out_pc, bus.out_inst, eo[63:32], eo[31:0], $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    hit_mode     = 1'b0;
    miss_ack     = 1'b0;
    bus.stall    = 1'b1;
    bus.jal      = 1'b0;
    bus.branch   = 1'b0;
    bus.j_target = '0;
    bus.b_target = '0;
    step();
    step();
    check("leftover_req", 32'(exp_req.size()), 32'd0);
    check("leftover_pop", 32'(exp_out.size()), 32'd0);
    exp_req.delete();
    exp_out.delete();
  endtask

  initial begin
    bus.stall = 1'b1; bus.jal = 1'b0; bus.branch = 1'b0;
    bus.j_target = '0; bus.b_target = '0;
    step(); step();
    check("rst_req_valid", 32'(bus.req_valid), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_inst", bus.out_inst, 32'h0000_0013);
    check("rst_out_pc", bus.out_pc, 32'hFFFF_FFFC);

    // 1: streaming hits, no stall
    do_reset();
    hit_mode = 1'b1; bus.stall = 1'b0;
    for (int i = 0; i < 6; i++) exp_req.push_back(32'(4 * i));
    for (int i = 0; i < 5; i++) exp_out.push_back({32'(4 * i), hit_inst(32'(4 * i))});
    rst = 1'b1;
    check("t1_latency", 32'(bus.out_valid), 32'd0);
    repeat (6) step();

    // 2: stall fills the FIFO, release drains without bubbles
    do_reset();
    hit_mode = 1'b1; bus.stall = 1'b1;
    for (int i = 0; i < 9; i++) exp_req.push_back(32'(4 * i));
    for (int i = 0; i < 5; i++) exp_out.push_back({32'(4 * i), hit_inst(32'(4 * i))});
    rst = 1'b1;
    repeat (10) step();
    check("t2_full_req_valid", 32'(bus.req_valid), 32'd0);
    check("t2_held_out_pc", bus.out_pc, 32'h0);
    bus.stall = 1'b0;
    repeat (5) step();

    // 3: miss at 0x20 answered five cycles later
    do_reset();
    bus.stall = 1'b0; bus.branch = 1'b1; bus.b_target = 32'h20;
    exp_req.push_back(32'h20); exp_req.push_back(32'h24);
    exp_out.push_back({32'h20, 32'h1234_5678});
    rst = 1'b1;
    step();
    bus.branch = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("t3_miss_out_valid", 32'(bus.out_valid), 32'd0);
      check("t3_miss_out_inst", bus.out_inst, 32'h0000_0013);
      step();
    end
    miss_ack = 1'b1; miss_inst = 32'h1234_5678;
    step();
    miss_ack = 1'b0;
    step();

    // 4: jal while a miss is outstanding drops the stale response
    do_reset();
    bus.stall = 1'b0; bus.branch = 1'b1; bus.b_target = 32'h40;
    exp_req.push_back(32'h40); exp_req.push_back(32'h100); exp_req.push_back(32'h104);
    exp_out.push_back({32'h100, 32'h0100_CAFE});
    rst = 1'b1;
    step();
    bus.branch = 1'b0;
    step();
    bus.jal = 1'b1; bus.j_target = 32'h100;
    step();
    bus.jal = 1'b0; miss_ack = 1'b1; miss_inst = 32'hBAD0_BAD0;
    check("t4_drop_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    miss_ack = 1'b0;
    check("t4_after_drop_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    miss_ack = 1'b1; miss_inst = 32'h0100_CAFE;
    step();
    miss_ack = 1'b0;
    step();

    // 5: jal and branch together on a full FIFO; jal wins
    do_reset();
    hit_mode = 1'b1; bus.stall = 1'b1;
    for (int i = 0; i < 4; i++) exp_req.push_back(32'(4 * i));
    exp_req.push_back(32'h200); exp_req.push_back(32'h204); exp_req.push_back(32'h208);
    exp_out.push_back({32'h200, hit_inst(32'h200)});
    exp_out.push_back({32'h204, hit_inst(32'h204)});
    rst = 1'b1;
    repeat (5) step();
    check("t5_full_req_valid", 32'(bus.req_valid), 32'd0);
    bus.jal = 1'b1; bus.j_target = 32'h200;
    bus.branch = 1'b1; bus.b_target = 32'h300;
    step();
    bus.jal = 1'b0; bus.branch = 1'b0; bus.stall = 1'b0;
    check("t5_redir_out_pc", bus.out_pc, 32'h200);
    check("t5_redir_out_inst", bus.out_inst, hit_inst(32'h200));
    step();
    step();

    // 6: reset during WAIT; an ack under reset is forgotten
    do_reset();
    bus.stall = 1'b0;
    exp_req.push_back(32'h0); exp_req.push_back(32'h0); exp_req.push_back(32'h4);
    exp_out.push_back({32'h0, 32'h600D_600D});
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    miss_ack = 1'b1; miss_inst = 32'hDEAD_BEEF;
    step();
    miss_ack = 1'b0;
    check("t6_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rst_req_valid", 32'(bus.req_valid), 32'd0);
    step();
    rst = 1'b1;
    check("t6_restart_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    check("t6_wait_out_valid", 32'(bus.out_valid), 32'd0);
    step();
    miss_ack = 1'b1; miss_inst = 32'h600D_600D;
    step();
    miss_ack = 1'b0;
    step();

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Parametrised next-generation fetch stage: decouples instruction fetch from decode with a DEPTH-entry prefetch FIFO of {pc, inst} pairs.
- Keeps issuing sequential cache requests while decode is stalled, until the FIFO is full.
- Handles jal/branch redirects at any point: flushes the FIFO and discards a stale in-flight cache response.
- Sits between the instruction cache and decode.

Parameters:
XLEN, 32, address/instruction width
DEPTH, 4, prefetch FIFO entries; power of 2, >= 2
RESET_PC, 0, address of first fetch after reset
NOP, 32'h00000013, instruction presented while the FIFO is empty

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset (asserted at 0)
req_valid  out  1  single-cycle cache request pulse
req_addr  out  XLEN  request address; valid when req_valid=1
cache_ack  in  1  response valid; may arrive in the same cycle as req_valid (hit)
cache_inst  in  XLEN  response data, valid with cache_ack
stall  in  1  decode not accepting this cycle
jal  in  1  redirect to j_target; priority over branch
branch  in  1  redirect to b_target
j_target  in  XLEN  jal target
b_target  in  XLEN  branch target
out_valid  out  1  FIFO non-empty
out_pc  out  XLEN  head pc; RESET_PC-4 while empty
out_inst  out  XLEN  head instruction; NOP while empty

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty (count=0), drop flag clear.
  - req_valid=0, out_valid=0, out_inst=NOP, out_pc=RESET_PC-4.
- Reset mid-miss: the pending response is forgotten; a late cache_ack arriving in IDLE with no request is ignored.
- Redirect:
  - redir = jal|branch; redir_tgt = jal ? j_target : b_target.
  - A redirect always flushes the FIFO (count becomes 0); any pop or normal push in that cycle is void.
- Pop: when out_valid && !stall, the head is consumed at the clock edge. out_* always reflect the registered head, so decode sees zero combinational path from cache.
- Count: width $clog2(DEPTH)+1. Simultaneous push and pop leaves count unchanged. Pointers wrap modulo DEPTH. At most one request outstanding.
- State IDLE (no request outstanding):
  - redir: req_valid=1, req_addr=redir_tgt.
    - ack this cycle: FIFO = {redir_tgt, cache_inst} only; fetch_pc=redir_tgt+4.
    - no ack: go WAIT; fetch_pc=redir_tgt.
  - else if count<DEPTH, or count==DEPTH with a pop this cycle: req_valid=1, req_addr=fetch_pc.
    - ack this cycle: push {fetch_pc, cache_inst}; fetch_pc+=4.
    - no ack: go WAIT.
  - else (full, no pop): req_valid=0.
- State WAIT (request outstanding for fetch_pc; req_valid=0):
  - ack && !redir: push {fetch_pc, cache_inst}, fetch_pc+=4, go IDLE. Space is guaranteed because the request was issued with space reserved.
  - ack && redir: discard the response, flush, fetch_pc=redir_tgt, go IDLE; the request issues next cycle.
  - !ack && redir: flush, fetch_pc=redir_tgt, go WAIT_DROP.
- State WAIT_DROP (stale request outstanding; req_valid=0):
  - Any redir updates fetch_pc=redir_tgt and flushes.
  - ack: discard cache_inst, go IDLE.
- Issue with reserved space: when a request is issued with count==DEPTH-1 and no ack, IDLE blocks further issue. Full is evaluated as count + outstanding >= DEPTH.
- stall never blocks fetching; it only blocks pops. jal and branch together: jal wins.
- Latency: hit with empty FIFO → out_valid on the next cycle.

Test Plan:
1. Reset then release, cache always acks same cycle, stall=0 → req_addr 0,4,8…; out_pc 0,4,8… on consecutive cycles after 1-cycle latency; out_inst = cache_inst values.
2. Same-cycle hits, stall=1 held for 10 cycles with DEPTH=4 → exactly 4 requests (0,4,8,12), then req_valid=0; out_pc stays 0. Release stall → 0,4,8,12,16 pop in order with no bubble.
3. Miss: ack 5 cycles after request at addr 0x20 → out_valid=0 / out_inst=NOP meanwhile; then {0x20, inst} appears the cycle after ack.
4. Miss outstanding at 0x40, jal=1 with j_target=0x100 two cycles later → WAIT_DROP; the 0x40 data never reaches out; next request is 0x100; FIFO empty after the jal cycle.
5. jal=1 (0x200) and branch=1 (0x300) in the same IDLE cycle with a full FIFO → flush; req_addr=0x200; out_pc=0x200 next cycle on hit.
6. Assert rst=0 in WAIT, deassert, then a stale cache_ack arrives → ignored; first request after reset = RESET_PC; out_valid=0 until its ack.
